audio_sample_gatherer: RTL and testbench
========================================

Name: audio_sample_gatherer

Overview:
- Upstream feeder for the HDMI audio sample packet stage.
- Buffers stereo L-PCM samples (with per-channel valid/user bits) in a FIFO.
- On each packet load, pops up to 4 samples into registered subpacket slots.
- Maintains the IEC 60958 frame counter (mod 192) so channel-status bits and the block-start flag downstream stay aligned across packets.

Parameters:
- FIFO_DEPTH, 8: stereo-sample entries; power of two, >= 4.
- MAX_SAMPLES, 4: max samples popped per load; legal range 1..4; slots >= MAX_SAMPLES are never present.

Ports:
- clk_pixel  input  1  pixel clock; the single clock domain.
- reset_n  input  1  asynchronous, active-low reset.
- sample_valid  input  1  sample offered this cycle.
- sample_ready  output  1  FIFO can accept; high when occupancy < FIFO_DEPTH.
- sample_word  input  2x24  [0]=left, [1]=right audio word.
- sample_valid_bit  input  2  IEC valid bit, [0]=left, [1]=right.
- sample_user_bit  input  2  IEC user bit, [0]=left, [1]=right.
- packet_load  input  1  one-cycle pulse from the packet scheduler: latch the next packet.
- audio_available  output  1  FIFO occupancy >= 1.
- frame_counter  output  8  IEC frame index of slot 0 of the latched packet; range 0..191.
- audio_sample_word  output  4x2x24  latched sample words per slot/channel.
- valid_bit  output  4x2  latched valid bits.
- user_data_bit  output  4x2  latched user bits.
- audio_sample_word_present  output  4  slot i holds a real sample.

Behaviour:
- Reset (async assert, sync release): FIFO empty; sample_ready=1; audio_available=0; frame_counter=0; all slot outputs 0; present=4'b0000.
- Push: accepted on a rising edge when sample_valid && sample_ready. The entry is visible in occupancy/audio_available on the next cycle.
  - Offered sample while full (sample_ready=0): not stored. The source must hold it until it is accepted.
- Load: on a rising edge with packet_load=1:
  - n = min(occupancy, MAX_SAMPLES), where occupancy is the value before this edge. A push in the same cycle is not included in n.
  - Slots 0..n-1 get the n oldest entries, oldest in slot 0. present[i]=1 for i<n, 0 otherwise.
  - Slots not present are driven to 0 (words and bits).
  - Outputs update one cycle after the packet_load edge and hold until the next load.
- Frame counter:
  - On each load, frame_counter takes the running counter value (index of the oldest popped sample).
  - The running counter then advances by n: if (counter + n) >= 192, subtract 192, else add n. Compute in 9 bits.
  - Example: counter=190, n=4 -> frame_counter=190, next running=2. Downstream sees slots at frames 190, 191, 0, 1.
- Empty load (occupancy=0): present=0, all slots 0, frame_counter=running value, running counter unchanged.
- Simultaneous push and load with a full FIFO: pop frees n entries, but sample_ready for this cycle was already 0, so nothing is pushed. sample_ready rises next cycle.
- Simultaneous push and load, non-full: occupancy_next = occupancy + 1 - n.
- FIFO pointers: log2(FIFO_DEPTH) bits plus a wrap bit, so full and empty are distinguishable. Reads wrap modulo FIFO_DEPTH.
- packet_load held high for consecutive cycles: each cycle is a separate load.
- Mid-operation reset: all state is cleared, including the frame counter, and the next packet starts a new IEC block at frame 0.

Optional Feature:
- Macro: AUDIO_GATHERER_OVERFLOW_COUNT_EN.
- Defined:
  - Adds output overflow_count (16 bits, reset 0).
  - Increments, saturating at 16'hFFFF, on every cycle where sample_valid=1 and sample_ready=0.
  - Adds input overflow_clear (1 bit), which synchronously zeroes the count. Clear wins over an increment in the same cycle.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then push 4 samples L=24'h000001..4, R=24'h100001..4, then one packet_load:
  - Expect present=4'b1111, slot0 L=24'h000001, slot3 R=24'h100004, frame_counter=0.
  - Expect audio_available=0 the cycle after the load.
- Push 2 samples, load:
  - Expect present=4'b0011, slots 2..3 all zero, frame_counter=0.
  - Next load with FIFO empty: present=0, frame_counter=2.
- Stream 200 samples with a load every 4 accepted samples:
  - Expect frame_counter sequence 0, 4, ..., 188, then 0 (192 mod 192).
  - Repeat with 190 pre-consumed: 190 then 2.
- Fill to FIFO_DEPTH=8 with sample_valid held high:
  - sample_ready=0 at occupancy 8.
  - Pulse packet_load in the same cycle as an offered push: occupancy becomes 4 (no push); sample_ready=1 the next cycle.
- MAX_SAMPLES=2, push 4, two loads: each load gives present=4'b0011; frame_counter 0 then 2.
- With AUDIO_GATHERER_OVERFLOW_COUNT_EN, hold sample_valid for 5 cycles while full:
  - overflow_count=5.
  - Assert overflow_clear and sample_valid together: count becomes 0.
- Assert reset_n=0 mid-stream: all outputs are 0 asynchronously; the first packet after release has frame_counter=0.

Source files
------------

// File: rtl/audio_sample_gatherer_if.sv
// Sample-side and packet-side signals of the HDMI audio sample gatherer.
// With AUDIO_GATHERER_OVERFLOW_COUNT_EN defined, the overflow counter signals are added.
interface audio_sample_gatherer_if;
    // sample_valid/sample_ready: a stereo sample transfers on a rising clk_pixel edge
    // where both are high; the source holds word and bits stable until that edge.
    logic                   sample_valid;
    logic                   sample_ready;
    logic [1:0][23:0]       sample_word;
    logic [1:0]             sample_valid_bit;
    logic [1:0]             sample_user_bit;

    logic                   packet_load;
    logic                   audio_available;
    logic [7:0]             frame_counter;
    logic [3:0][1:0][23:0]  audio_sample_word;
    logic [3:0][1:0]        valid_bit;
    logic [3:0][1:0]        user_data_bit;
    logic [3:0]             audio_sample_word_present;

`ifdef AUDIO_GATHERER_OVERFLOW_COUNT_EN
    logic                   overflow_clear;
    logic [15:0]            overflow_count;
`endif

    modport master (
`ifdef AUDIO_GATHERER_OVERFLOW_COUNT_EN
        output overflow_clear,
        input  overflow_count,
`endif
        output sample_valid,
        input  sample_ready,
        output sample_word,
        output sample_valid_bit,
        output sample_user_bit,
        output packet_load,
        input  audio_available,
        input  frame_counter,
        input  audio_sample_word,
        input  valid_bit,
        input  user_data_bit,
        input  audio_sample_word_present
    );

    modport slave (
`ifdef AUDIO_GATHERER_OVERFLOW_COUNT_EN
        input  overflow_clear,
        output overflow_count,
`endif
        input  sample_valid,
        output sample_ready,
        input  sample_word,
        input  sample_valid_bit,
        input  sample_user_bit,
        input  packet_load,
        output audio_available,
        output frame_counter,
        output audio_sample_word,
        output valid_bit,
        output user_data_bit,
        output audio_sample_word_present
    );
endinterface

// File: rtl/audio_sample_gatherer.sv
// Stereo L-PCM sample FIFO feeding HDMI audio sample packets, with IEC 60958 frame tracking.
// Optional macro AUDIO_GATHERER_OVERFLOW_COUNT_EN adds a saturating overflow counter.
module audio_sample_gatherer #(
    parameter int FIFO_DEPTH  = 8,
    parameter int MAX_SAMPLES = 4
) (
    input  logic                    clk_pixel,
    input  logic                    reset_n,
    audio_sample_gatherer_if.slave  bus
);
    localparam int         AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_N = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] MAX_N   = (AW + 1)'(MAX_SAMPLES);
    localparam logic [8:0]  FRAMES  = 9'd192;

    logic [1:0][23:0]      r_word_mem [FIFO_DEPTH];
    logic [1:0]            r_vbit_mem [FIFO_DEPTH];
    logic [1:0]            r_ubit_mem [FIFO_DEPTH];

    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_rd_ptr;
    logic [7:0]            r_running;
    logic [7:0]            r_frame;
    logic [3:0][1:0][23:0] r_slot_word;
    logic [3:0][1:0]       r_slot_vbit;
    logic [3:0][1:0]       r_slot_ubit;
    logic [3:0]            r_present;

    logic [AW:0]           w_count;
    logic                  w_full;
    logic                  w_push;
    logic [AW:0]           w_n;
    logic [8:0]            w_sum;
    logic [8:0]            w_running_next;
    logic [3:0]            w_take;
    logic [AW-1:0]         w_rd_idx [4];

    // Pointer difference with the wrap bit gives occupancy 0..FIFO_DEPTH.
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_count == DEPTH_N);
    assign w_push  = bus.sample_valid && !w_full;
    assign w_n     = (w_count < MAX_N) ? w_count : MAX_N;

    // Running frame index wraps at the 192-frame IEC block boundary.
    assign w_sum          = {1'b0, r_running} + 9'(w_n);
    assign w_running_next = (w_sum >= FRAMES) ? (w_sum - FRAMES) : w_sum;

    always_comb begin
        w_take = '0;
        for (int i = 0; i < 4; i++) begin
            w_take[i]   = ((AW + 1)'(i) < w_n);
            w_rd_idx[i] = r_rd_ptr[AW-1:0] + AW'(i);
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (w_push) begin
            r_word_mem[r_wr_ptr[AW-1:0]] <= bus.sample_word;
            r_vbit_mem[r_wr_ptr[AW-1:0]] <= bus.sample_valid_bit;
            r_ubit_mem[r_wr_ptr[AW-1:0]] <= bus.sample_user_bit;
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_running   <= '0;
            r_frame     <= '0;
            r_slot_word <= '0;
            r_slot_vbit <= '0;
            r_slot_ubit <= '0;
            r_present   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (AW + 1)'(1);
            end
            if (bus.packet_load) begin
                r_rd_ptr  <= r_rd_ptr + w_n;
                r_frame   <= r_running;
                r_running <= w_running_next[7:0];
                r_present <= w_take;
                // Absent slots are zeroed so the packet stage can ignore them blindly.
                for (int i = 0; i < 4; i++) begin
                    if (w_take[i]) begin
                        r_slot_word[i] <= r_word_mem[w_rd_idx[i]];
                        r_slot_vbit[i] <= r_vbit_mem[w_rd_idx[i]];
                        r_slot_ubit[i] <= r_ubit_mem[w_rd_idx[i]];
                    end else begin
                        r_slot_word[i] <= '0;
                        r_slot_vbit[i] <= '0;
                        r_slot_ubit[i] <= '0;
                    end
                end
            end
        end
    end

    assign bus.sample_ready              = !w_full;
    assign bus.audio_available           = (w_count != '0);
    assign bus.frame_counter             = r_frame;
    assign bus.audio_sample_word         = r_slot_word;
    assign bus.valid_bit                 = r_slot_vbit;
    assign bus.user_data_bit             = r_slot_ubit;
    assign bus.audio_sample_word_present = r_present;

`ifdef AUDIO_GATHERER_OVERFLOW_COUNT_EN
    logic [15:0] r_ovf_count;

    // Clear has priority over a same-cycle overflow.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf_count <= '0;
        end else if (bus.overflow_clear) begin
            r_ovf_count <= '0;
        end else if (bus.sample_valid && w_full && (r_ovf_count != 16'hFFFF)) begin
            r_ovf_count <= r_ovf_count + 16'd1;
        end
    end

    assign bus.overflow_count = r_ovf_count;
`endif
endmodule

// File: tb/tb_audio_sample_gatherer.sv
// Randomized and directed bench for audio_sample_gatherer with a queue-based reference model.
module tb_audio_sample_gatherer;
    localparam int DEPTH = 8;
    localparam int MAXS  = 4;
    localparam int W     = 220;

    typedef struct packed {
        logic [1:0][23:0] w;
        logic [1:0]       vb;
        logic [1:0]       ub;
    } samp_t;

    logic clk_pixel = 1'b0;
    logic reset_n;
    always #5 clk_pixel = ~clk_pixel;

    audio_sample_gatherer_if aif();

    audio_sample_gatherer #(.FIFO_DEPTH(DEPTH), .MAX_SAMPLES(MAXS)) dut (
        .clk_pixel (clk_pixel),
        .reset_n   (reset_n),
        .bus       (aif)
    );

    int n_checks = 0;
    int n_pass   = 0;

    samp_t           mq[$];
    logic [W-1:0]    exp_q[$];
    int              running;
    int              m_pre;
    int              m_n;
    bit              m_acc;
    samp_t           m_s;
    logic [3:0]            m_pres;
    logic [3:0][1:0][23:0] m_words;
    logic [3:0][1:0]       m_vbs;
    logic [3:0][1:0]       m_ubs;
`ifdef AUDIO_GATHERER_OVERFLOW_COUNT_EN
    int              exp_ovf;
`endif

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    // Reference model: samples queue up, loads take the oldest min(occupancy, MAXS).
    always @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            running = 0;
`ifdef AUDIO_GATHERER_OVERFLOW_COUNT_EN
            exp_ovf = 0;
`endif
        end else begin
            m_pre = mq.size();
            m_acc = aif.sample_valid && (m_pre < DEPTH);
`ifdef AUDIO_GATHERER_OVERFLOW_COUNT_EN
            if (aif.overflow_clear) exp_ovf = 0;
            else if (aif.sample_valid && m_pre >= DEPTH && exp_ovf < 65535) exp_ovf++;
`endif
            if (aif.packet_load) begin
                m_n = (m_pre < MAXS) ? m_pre : MAXS;
                m_pres = '0; m_words = '0; m_vbs = '0; m_ubs = '0;
                for (int i = 0; i < m_n; i++) begin
                    m_s = mq.pop_front();
                    m_words[i] = m_s.w;
                    m_vbs[i]   = m_s.vb;
                    m_ubs[i]   = m_s.ub;
                    m_pres[i]  = 1'b1;
                end
                exp_q.push_back({8'(running), m_pres, m_words, m_vbs, m_ubs});
                running = (running + m_n) % 192;
            end
            if (m_acc) mq.push_back({aif.sample_word, aif.sample_valid_bit, aif.sample_user_bit});
        end
    end

    // Monitor: packet outputs appear one cycle after a load edge.
    bit           mon_ld;
    logic [W-1:0] mon_e;
    always begin
        @(posedge clk_pixel);
        mon_ld = reset_n && aif.packet_load;
        @(negedge clk_pixel);
        chk("sample_ready", aif.sample_ready, mq.size() < DEPTH);
        chk("audio_available", aif.audio_available, mq.size() != 0);
`ifdef AUDIO_GATHERER_OVERFLOW_COUNT_EN
        chk("overflow_count", aif.overflow_count, 16'(exp_ovf));
`endif
        if (mon_ld) begin
            if (exp_q.size() == 0) begin
                chk("exp_q_empty", 1'b1, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pkt_frame", aif.frame_counter, mon_e[219:212]);
                chk("pkt_present", aif.audio_sample_word_present, mon_e[211:208]);
                chk("pkt_words", aif.audio_sample_word, mon_e[207:16]);
                chk("pkt_valid_bits", aif.valid_bit, mon_e[15:8]);
                chk("pkt_user_bits", aif.user_data_bit, mon_e[7:0]);
            end
        end
    end

    function automatic samp_t rnd_samp();
        samp_t r;
        r.w[0] = 24'($urandom);
        r.w[1] = 24'($urandom);
        r.vb   = 2'($urandom_range(0, 3));
        r.ub   = 2'($urandom_range(0, 3));
        return r;
    endfunction

    // Drive one cycle starting at a negedge; acc reports whether a push transfers.
    task automatic cycle(input bit v, input samp_t s, input bit ld, input bit clr, output bit acc);
        aif.sample_valid     = v;
        aif.sample_word      = s.w;
        aif.sample_valid_bit = s.vb;
        aif.sample_user_bit  = s.ub;
        aif.packet_load      = ld;
`ifdef AUDIO_GATHERER_OVERFLOW_COUNT_EN
        aif.overflow_clear   = clr;
`else
        if (clr) aif.packet_load = ld;
`endif
        acc = v && aif.sample_ready;
        @(negedge clk_pixel);
    endtask

    task automatic push(input samp_t s);
        bit acc;
        int g = 0;
        do begin
            cycle(1'b1, s, 1'b0, 1'b0, acc);
            g++;
        end while (!acc && g < 64);
        if (!acc) chk("push_timeout", 1'b0, 1'b1);
    endtask

    task automatic load();
        bit acc;
        cycle(1'b0, '0, 1'b1, 1'b0, acc);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, acc);
    endtask

    task automatic push_n(input int n);
        for (int i = 0; i < n; i++) push(rnd_samp());
    endtask

    task automatic do_reset();
        aif.sample_valid = 1'b0;
        aif.packet_load  = 1'b0;
`ifdef AUDIO_GATHERER_OVERFLOW_COUNT_EN
        aif.overflow_clear = 1'b0;
`endif
        reset_n = 1'b0;
        repeat (2) @(negedge clk_pixel);
        reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        samp_t s;
        samp_t pend;
        bit    acc;
        bit    v;
        bit    ld;
        aif.sample_word      = '0;
        aif.sample_valid_bit = '0;
        aif.sample_user_bit  = '0;
        do_reset();

        chk("reset_present", aif.audio_sample_word_present, 4'b0000);
        chk("reset_frame", aif.frame_counter, 8'd0);
        chk("reset_ready", aif.sample_ready, 1'b1);
        chk("reset_available", aif.audio_available, 1'b0);

        for (int k = 1; k <= 4; k++) begin
            s = rnd_samp();
            s.w[0] = 24'(k);
            s.w[1] = 24'h100000 + 24'(k);
            push(s);
        end
        load();
        chk("t1_present", aif.audio_sample_word_present, 4'b1111);
        chk("t1_slot0_left", aif.audio_sample_word[0][0], 24'h000001);
        chk("t1_slot3_right", aif.audio_sample_word[3][1], 24'h100004);
        chk("t1_frame", aif.frame_counter, 8'd0);
        chk("t1_available", aif.audio_available, 1'b0);

        do_reset();
        push_n(2);
        load();
        chk("t2_present", aif.audio_sample_word_present, 4'b0011);
        chk("t2_slot2_zero", aif.audio_sample_word[2], 48'd0);
        chk("t2_slot3_zero", aif.audio_sample_word[3], 48'd0);
        chk("t2_frame", aif.frame_counter, 8'd0);
        load();
        chk("t2_empty_present", aif.audio_sample_word_present, 4'b0000);
        chk("t2_empty_frame", aif.frame_counter, 8'd2);

        do_reset();
        for (int k = 0; k < 50; k++) begin
            push_n(4);
            load();
            if (k == 47) chk("t3_frame_188", aif.frame_counter, 8'd188);
            if (k == 48) chk("t3_frame_wrap", aif.frame_counter, 8'd0);
        end

        do_reset();
        for (int k = 0; k < 47; k++) begin
            push_n(4);
            load();
        end
        push_n(2);
        load();
        push_n(4);
        load();
        chk("t4_frame_190", aif.frame_counter, 8'd190);
        push_n(4);
        load();
        chk("t4_frame_2", aif.frame_counter, 8'd2);

        do_reset();
        push_n(DEPTH);
        chk("t5_full_ready", aif.sample_ready, 1'b0);
        pend = rnd_samp();
        cycle(1'b1, pend, 1'b1, 1'b0, acc);
        chk("t5_push_blocked", acc, 1'b0);
        chk("t5_ready_after_load", aif.sample_ready, 1'b1);
        push(pend);
        load();
        load();

`ifdef AUDIO_GATHERER_OVERFLOW_COUNT_EN
        do_reset();
        push_n(DEPTH);
        for (int i = 0; i < 5; i++) cycle(1'b1, pend, 1'b0, 1'b0, acc);
        chk("t6_overflow_5", aif.overflow_count, 16'd5);
        cycle(1'b1, pend, 1'b0, 1'b1, acc);
        chk("t6_overflow_clear", aif.overflow_count, 16'd0);
        aif.overflow_clear = 1'b0;
`endif

        do_reset();
        pend = rnd_samp();
        for (int i = 0; i < 1500; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            ld = ($urandom_range(0, 4) == 0);
            cycle(v, pend, ld, 1'b0, acc);
            if (acc) pend = rnd_samp();
        end
        idle(1);

        push_n(3);
        load();
        push_n(2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_reset_present", aif.audio_sample_word_present, 4'b0000);
        chk("mid_reset_frame", aif.frame_counter, 8'd0);
        chk("mid_reset_words", aif.audio_sample_word, 192'd0);
        chk("mid_reset_vbits", aif.valid_bit, 8'd0);
        chk("mid_reset_ubits", aif.user_data_bit, 8'd0);
        chk("mid_reset_available", aif.audio_available, 1'b0);
        chk("mid_reset_ready", aif.sample_ready, 1'b1);
        @(negedge clk_pixel);
        reset_n = 1'b1;
        push_n(4);
        load();
        chk("post_reset_frame", aif.frame_counter, 8'd0);
        chk("post_reset_present", aif.audio_sample_word_present, 4'b1111);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
